button_event_scheduler: RTL and testbench

Multi-button front end that shares one debounce tick generator across `NUM_BTN` raw pushbuttons. It filters each button and turns each debounced press into an event code. Pending events are serialised through a round-robin arbiter into a small FIFO. The FIFO drains over a valid/ready handshake to the lab datapath, for example a processor input port or a register-write sequencer. It replaces per-button debouncer instances, each with its own 30-bit counter, with one shared scheduler.

---
 rtl/button_event_scheduler.sv | 162 ++++++++++++++++
 tb/tb_button_event_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_scheduler.sv
// Shared-tick debouncer for NUM_BTN pushbuttons. Debounced presses are
// serialised by a round-robin arbiter into a small event FIFO drained over valid/ready.
module button_event_scheduler #(
  parameter int NUM_BTN    = 4,
  parameter int TICK_DIV   = 250000,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(NUM_BTN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BTN-1:0]            btn_in,
  output logic                          evt_valid,
  output logic [IDW-1:0]                evt_id,
  input  logic                          evt_ready,
  output logic [NUM_BTN-1:0]            btn_level,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [IDW-1:0] LAST_RST  = IDW'(NUM_BTN - 1);
  localparam logic [AW:0]    FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [2:0]         hist_q [NUM_BTN];
  logic [2:0]         hist_d [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] gnt_oh;
  logic [IDW-1:0]     last_q, last_d;
  logic               overflow_q, overflow_d;
  logic               gnt_vld;
  logic [IDW-1:0]     gnt_idx;
  logic               fifo_full;
  logic               push, pop;
  logic [IDW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;

  // Shared slow-sample tick: registered compare, one pulse every TICK_DIV cycles
  assign cnt_d  = (cnt_q == TICK_LAST) ? '0 : cnt_q + CW'(1);
  assign tick_d = (cnt_q == TICK_LAST);

  // Sample history and hysteresis level; level reacts to the registered history
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      hist_d[i]  = tick_q ? {hist_q[i][1:0], sync2_q[i]} : hist_q[i];
      level_d[i] = level_q[i];
      if (hist_q[i] == 3'b111) begin
        level_d[i] = 1'b1;
      end else if (hist_q[i] == 3'b000) begin
        level_d[i] = 1'b0;
      end
    end
  end

  assign rise = level_d & ~level_q;

  // Round-robin search starting just after the last granted index
  assign fifo_full = (count_q == FULL_CNT);

  always_comb begin : arb
    logic [IDW:0]   sum;
    logic [IDW-1:0] cand;
    sum     = '0;
    cand    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      sum = {1'b0, last_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_BTN)) begin
        sum = sum - (IDW+1)'(NUM_BTN);
      end
      cand = sum[IDW-1:0];
      if (!gnt_vld && !fifo_full && pending_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) begin
      gnt_oh[gnt_idx] = 1'b1;
    end
  end

  // A new press on the granting edge wins over the clear
  assign pending_d  = (pending_q & ~gnt_oh) | rise;
  assign last_d     = gnt_vld ? gnt_idx : last_q;
  assign overflow_d = overflow_q | (|(rise & pending_q));

  // Event FIFO: push only when not full, no bypass
  assign push      = gnt_vld;
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      level_q    <= '0;
      pending_q  <= '0;
      last_q     <= LAST_RST;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        hist_q[i] <= 3'b000;
      end
    end else begin
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      level_q    <= level_d;
      pending_q  <= pending_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  // Storage is qualified by the pointers and count, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= gnt_idx;
    end
  end

  assign evt_id     = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign btn_level  = level_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: table of press patterns with expected event
// order, hand sequences for timing, backpressure and resets, and an event scoreboard.
module tb_button_event_scheduler;

  localparam int NB = 4;
  localparam int TD = 4;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = 4'h0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] btn_level;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0]      mask;
    int              n;
    logic [3:0][1:0] ids;
  } vec_t;

  vec_t vt[6];

  button_event_scheduler #(
    .NUM_BTN(NB),
    .TICK_DIV(TD),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .evt_valid(evt_valid),
    .evt_id(evt_id),
    .evt_ready(evt_ready),
    .btn_level(btn_level),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_range(input string nm, input int val, input int lo, input int hi);
    checks++;
    if (val < lo || val > hi) begin
      errors++;
      $display("FAIL %s: got %0d cycles expected %0d..%0d", nm, val, lo, hi);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] m, input int n,
                              input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] c, input logic [1:0] d);
    vec_t r;
    r.mask   = m;
    r.n      = n;
    r.ids[0] = a;
    r.ids[1] = b;
    r.ids[2] = c;
    r.ids[3] = d;
    return r;
  endfunction

  // Scoreboard consumer and stall-stability monitor, sampled between edges
  logic       stall_q = 1'b0;
  logic [1:0] stall_id = 2'd0;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && evt_valid) check("stall_id_stable", evt_id, stall_id);
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL evt_spurious: got id %0d expected no event", evt_id);
        end else begin
          check("evt_order", evt_id, exp_q.pop_front());
        end
      end
      stall_q  = evt_valid && !evt_ready;
      stall_id = evt_id;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input logic [3:0] exp, input string nm);
    int n = 0;
    while (btn_level !== exp && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, btn_level, exp);
  endtask

  task automatic press_release(input logic [3:0] m, input string nm);
    btn_in = m;
    wait_level(m, {nm, "_rise"});
    btn_in = 4'h0;
    wait_level(4'h0, {nm, "_fall"});
  endtask

  initial begin
    int   n;
    logic seen;

    vt[0] = mk(4'b1011, 3, 2'd0, 2'd1, 2'd3, 2'd0);
    vt[1] = mk(4'b1001, 2, 2'd0, 2'd3, 2'd0, 2'd0);
    vt[2] = mk(4'b0010, 1, 2'd1, 2'd0, 2'd0, 2'd0);
    vt[3] = mk(4'b1001, 2, 2'd3, 2'd0, 2'd0, 2'd0);
    vt[4] = mk(4'b0100, 1, 2'd2, 2'd0, 2'd0, 2'd0);
    vt[5] = mk(4'b1111, 4, 2'd3, 2'd0, 2'd1, 2'd2);

    // Reset with every button held
    rst       = 1'b1;
    btn_in    = 4'hF;
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_outputs_zero", {evt_valid, evt_id, btn_level, fifo_count, overflow}, 0);
    end
    rst = 1'b0;
    cyc(8);
    check("rst_no_early_valid", evt_valid, 0);
    check("rst_no_early_level", btn_level, 0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    wait_level(4'hF, "rst_refill_rise");
    btn_in = 4'h0;
    wait_level(4'h0, "rst_refill_fall");
    cyc(10);
    check("rst_refill_drained", exp_q.size(), 0);

    // Single press of button 2 with latency checks
    exp_q.push_back(2'd2);
    btn_in = 4'b0100;
    n = 0;
    while (!btn_level[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_range("press_latency", n, 12, 15);
    check("press_valid_before_write", evt_valid, 0);
    @(negedge clk);
    check("press_valid_after_write", evt_valid, 1);
    check("press_id", evt_id, 2);
    cyc(20);
    btn_in = 4'h0;
    n = 0;
    while (btn_level[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_range("release_latency", n, 12, 15);
    cyc(20);
    check("single_drained", exp_q.size(), 0);
    check("single_count", fifo_count, 0);

    // Short bounce never qualifies
    btn_in = 4'b0010;
    cyc(6);
    btn_in = 4'h0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (btn_level[1]) seen = 1'b1;
    end
    check("bounce_level", seen, 0);
    check("bounce_overflow", overflow, 0);
    check("bounce_count", fifo_count, 0);

    // Round-robin table from a fresh reset (button 0 first)
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vt[v].n; k++) exp_q.push_back(vt[v].ids[k]);
      press_release(vt[v].mask, $sformatf("rr%0d", v));
      cyc(8);
      check($sformatf("rr%0d_drained", v), exp_q.size(), 0);
      check($sformatf("rr%0d_count", v), fifo_count, 0);
    end

    // Backpressure: fill, then lose one press to a merge
    evt_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(2'(b));
      press_release(4'(1 << b), $sformatf("bp_fill%0d", b));
    end
    check("bp_full_count", fifo_count, 4);
    check("bp_no_overflow_yet", overflow, 0);
    exp_q.push_back(2'd2);
    press_release(4'b0100, "bp_extra1");
    check("bp_extra1_count", fifo_count, 4);
    check("bp_extra1_overflow", overflow, 0);
    press_release(4'b0100, "bp_extra2");
    check("bp_extra2_overflow", overflow, 1);
    check("bp_extra2_count", fifo_count, 4);
    evt_ready = 1'b1;
    cyc(20);
    check("bp_drained", exp_q.size(), 0);
    check("bp_empty_count", fifo_count, 0);
    check("bp_overflow_sticky", overflow, 1);

    // Reset while two entries are queued and one press is pending
    evt_ready = 1'b0;
    exp_q.push_back(2'd0);
    press_release(4'b0001, "mr_a");
    exp_q.push_back(2'd1);
    press_release(4'b0010, "mr_b");
    check("mr_count_before", fifo_count, 2);
    btn_in = 4'b1000;
    n = 0;
    while (!btn_level[3] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mr_pending_level", btn_level, 4'b1000);
    check("mr_count_at_pending", fifo_count, 2);
    rst    = 1'b1;
    btn_in = 4'h0;
    @(negedge clk);
    check("mr_count_cleared", fifo_count, 0);
    check("mr_valid_cleared", evt_valid, 0);
    check("mr_id_cleared", evt_id, 0);
    check("mr_overflow_cleared", overflow, 0);
    check("mr_level_cleared", btn_level, 0);
    exp_q.delete();
    rst       = 1'b0;
    evt_ready = 1'b1;
    cyc(40);
    check("mr_no_stale_valid", evt_valid, 0);
    check("mr_no_stale_count", fifo_count, 0);
    exp_q.push_back(2'd3);
    press_release(4'b1000, "mr_after");
    cyc(8);
    check("mr_after_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
